mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Upstream sequencer for the 4-to-1 logic mux. It drives the mux select lines `s1`/`s0` through channels 0→3, holds each channel for a programmable dwell time, and samples the mux output `y` at the end of each dwell. The four samples are published together as one 4-bit snapshot with a done pulse. It runs single-shot or continuous, under a start/stop handshake.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the dwell-count input and the internal counter.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a scan frame. Honoured only in IDLE.
- `stop`, in, 1: abort. Has priority over `start`.
- `mode`, in, 1: 0 = single frame; 1 = continuous frames.
- `dwell`, in, DWELL_W: cycles per channel. A value of 0 is treated as 1. Latched at frame start.
- `y`, in, 1: mux output.
- `s1`, out, 1: mux select MSB.
- `s0`, out, 1: mux select LSB.
- `busy`, out, 1: high while a frame is in progress.
- `done`, out, 1: one-cycle pulse when `snap` updates.
- `snap`, out, 4: last complete frame. Bit k holds `y` sampled with select = k.

## Operation
States:
- IDLE
- SCAN

Reset values (asynchronous on `rst_n` low):
- state IDLE, `{s1,s0}`=00, `busy`=0, `done`=0, `snap`=0.
- Internal registers cleared: counter, channel index, shadow register.

In IDLE, `{s1,s0}` holds 00.

IDLE → SCAN, when `start`=1 and `stop`=0 at a clock edge:
- Latch D = max(`dwell`,1).
- Set channel index to 0, counter to D-1, `busy`=1.

SCAN, on each edge:
- If counter ≠ 0: decrement it.
- If counter = 0: write `y` into shadow bit k, where k = current channel.
  - k < 3: k←k+1, counter←D-1.
  - k = 3: `snap`←shadow with bit 3 replaced by the current `y`, and `done`=1 for the next cycle. Then:
    - `mode`=1: k←0, reload D from `dwell`, counter←D-1, stay in SCAN. No gap cycle.
    - `mode`=0: go to IDLE, `busy`←0, `{s1,s0}`←00.

`{s1,s0}` always equals the registered channel index. Outputs are glitch-free; there is no combinational path from `y`.

Boundary rules:
- `start` while busy: ignored. No restart, no error.
- `stop`=1 on any edge in SCAN: go to IDLE. `busy`←0, `{s1,s0}`←00, shadow discarded, `snap` unchanged, no `done`.
- `stop` on the same edge as the final sample: the stop wins, so `snap` is not updated and there is no `done`.
- `dwell` or `mode` changing mid-frame: `dwell` has no effect until the next frame load. `mode` is sampled only at the k=3 completion edge.
- `rst_n` asserted mid-frame: immediate return to the reset values. No `done`.
- D=1: each channel lasts one cycle, so a frame is 4 cycles.

## Timing
- Let E0 be the edge that accepts `start`.
- Channel k is driven during the cycles between edges E0+kD and E0+(k+1)D.
- `y` for channel k is sampled at edge E0+(k+1)D. The mux combinational delay must fit in one cycle.
- `snap` and `done` update at edge E0+4D, so `done` is high during the cycle that follows.
- Single-shot: `busy` is high from E0 to E0+4D, then falls.
- Continuous: the next frame's channel 0 is driven from edge E0+4D. Frame period = 4D cycles.

## Structure
- Package `mux4_scan_pkg`:
  - state enum `{IDLE, SCAN}`
  - `CH_NUM`=4
  - `SEL_W`=2
  - `LAST_CH`=2'd3
- Sub-module `scan_dwell_timer`: loadable down-counter, DWELL_W bits, with `load`, `load_val`, and `zero` output. Instantiated once.
- Everything else (FSM, channel index, shadow register, snap) lives in the top module.

## Test plan
- Reset mid-frame: `rst_n` pulsed low asynchronously between edges → all outputs immediately take their reset values; next `start` begins a fresh frame at channel 0.
- Single-shot: `dwell`=2, `mode`=0, `y` driven as a=1, b=0, c=1, d=1 per select → select sequence 00,00,01,01,10,10,11,11; `snap`=4'b1101; `done` is a one-cycle pulse after E0+8; `busy` falls at the same edge.
- Dwell 0: `dwell`=0 → behaves as D=1; frame completes at E0+4.
- Continuous: `dwell`=1, `mode`=1, `y` changes between frames → `done` every 4 cycles; `snap` tracks each frame; select wraps 11→00 with no gap. Clearing `mode` mid-frame completes that frame and then goes IDLE.
- Stop: `stop` asserted at E0+5 with D=2 → IDLE the next cycle, `{s1,s0}`=00, `snap` retains the previous value, no `done`. `stop` together with `start` in IDLE → stays IDLE.
- Ignored inputs mid-frame: `start` pulses and a `dwell` change during SCAN → frame timing unchanged; the new `dwell` applies only to the following continuous frame.

Source files
------------

// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
// State encoding plus channel-count constants.
package mux4_scan_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int CH_NUM = 4;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter that measures the dwell on one mux channel.
// Holds at zero until the next load.
module scan_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Sequences a 4:1 mux through its channels, samples y at the end of
// each dwell and publishes the four samples as one snapshot.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic               done,
  output logic [CH_NUM-1:0]  snap
);

  state_t state, state_nx;

  logic [SEL_W-1:0]   ch;
  logic [DWELL_W-1:0] dlat;
  logic [DWELL_W-1:0] dnew;
  logic [DWELL_W-1:0] ld_val;
  logic [CH_NUM-1:0]  shadow;

  logic tm_zero;
  logic tm_load;
  logic accept;
  logic abort;
  logic step;
  logic fin;
  logic reload;

  assign dnew = (dwell == '0) ? DWELL_W'(1) : dwell;

  scan_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tm_load),
    .load_val (ld_val),
    .zero     (tm_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && !stop) state_nx = SCAN;
      end
      SCAN: begin
        if (stop) state_nx = IDLE;
        else if (fin && !mode) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A frame reload (start or continuous wrap) takes the live dwell.
  always_comb begin
    accept  = (state == IDLE) && start && !stop;
    abort   = (state == SCAN) && stop;
    step    = (state == SCAN) && !stop && tm_zero;
    fin     = step && (ch == LAST_CH);
    reload  = accept || (fin && mode);
    tm_load = reload || (step && !fin);
    ld_val  = (reload ? dnew : dlat) - DWELL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlat   <= '0;
      ch     <= '0;
      shadow <= '0;
      snap   <= '0;
      done   <= 1'b0;
    end else begin
      done <= fin;
      if (reload) dlat <= dnew;
      if (abort || accept) begin
        ch     <= '0;
        shadow <= '0;
      end else if (step) begin
        ch         <= ch + SEL_W'(1);
        shadow[ch] <= y;
      end
      if (fin) snap <= {y, shadow[CH_NUM-2:0]};
    end
  end

  assign busy = (state == SCAN);
  assign s1   = ch[1];
  assign s0   = ch[0];

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl with a behavioural mux model on y.
// Expected per-cycle outputs are queued by stimulus, checked by a monitor.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] dwell = 4'd0;
  logic [3:0] pat = 4'd0;
  logic       y;
  logic       s1, s0, busy, done;
  logic [3:0] snap;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] snap_m = 4'd0;

  typedef struct {
    int         c;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] snap;
  } exp_t;

  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y = pat[{s1, s0}];

  mux4_scan_ctrl #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .y     (y),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy),
    .done  (done),
    .snap  (snap)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic [1:0] sel, input logic b,
                      input logic d, input logic [3:0] sn);
    exp_t e;
    e.c = c; e.sel = sel; e.busy = b; e.done = d; e.snap = sn;
    q.push_back(e);
  endtask

  // Channel k occupies cycles [e0+k*D, e0+(k+1)*D); snap lands at e0+4D.
  task automatic push_frame(input int e0, input int d, input logic [3:0] p,
                            input bit first_done, input bit last);
    int dd;
    int c;
    dd = (d == 0) ? 1 : d;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < dd; t++) begin
        c = e0 + k * dd + t;
        push(c, 2'(k), 1'b1, (c == e0) ? first_done : 1'b0, snap_m);
      end
    end
    snap_m = p;
    if (last) push(e0 + 4 * dd, 2'd0, 1'b0, 1'b1, p);
  endtask

  task automatic trim(input int c);
    while (q.size() > 0 && q[$].c >= c) void'(q.pop_back());
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic single(input int d, input logic [3:0] p);
    int e0;
    int dd;
    @(negedge clk);
    dd = (d == 0) ? 1 : d;
    dwell = 4'(d); mode = 1'b0; pat = p; start = 1'b1;
    e0 = cyc + 1;
    push_frame(e0, d, p, 1'b0, 1'b1);
    wait_cyc(e0);
    start = 1'b0;
    wait_cyc(e0 + 4 * dd + 1);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_entry cyc=%0d actual=%0d required=%0d",
               cyc, cyc, q[0].c);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].c == cyc) begin
      me = q.pop_front();
      chk("sel", {s1, s0}, me.sel);
      chk("busy", busy, me.busy);
      chk("done", done, me.done);
      chk("snap", snap, me.snap);
    end else begin
      chk("done_idle", done, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    int c;
    logic [3:0] p0, p1, p2, sv;

    repeat (2) @(negedge clk);
    chk("rst_sel", {s1, s0}, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_snap", snap, 4'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // a=1 b=0 c=1 d=1
    single(2, 4'b1101);
    single(0, 4'($urandom));

    // continuous D=1, start pulse mid-frame, mode cleared in frame 3
    p0 = 4'($urandom); p1 = 4'($urandom); p2 = 4'($urandom);
    @(negedge clk);
    dwell = 4'd1; mode = 1'b1; pat = p0; start = 1'b1;
    e0 = cyc + 1;
    push_frame(e0, 1, p0, 1'b0, 1'b0);
    push_frame(e0 + 4, 1, p1, 1'b1, 1'b0);
    push_frame(e0 + 8, 1, p2, 1'b1, 1'b1);
    wait_cyc(e0); start = 1'b0;
    wait_cyc(e0 + 4); pat = p1;
    wait_cyc(e0 + 5); start = 1'b1;
    wait_cyc(e0 + 6); start = 1'b0;
    wait_cyc(e0 + 8); pat = p2;
    wait_cyc(e0 + 9); mode = 1'b0;
    wait_cyc(e0 + 13);

    // dwell change mid-frame takes effect on the next continuous frame
    p0 = 4'($urandom); p1 = 4'($urandom);
    @(negedge clk);
    dwell = 4'd3; mode = 1'b1; pat = p0; start = 1'b1;
    e0 = cyc + 1;
    push_frame(e0, 3, p0, 1'b0, 1'b0);
    push_frame(e0 + 12, 2, p1, 1'b1, 1'b1);
    wait_cyc(e0); start = 1'b0;
    wait_cyc(e0 + 2); dwell = 4'd2; start = 1'b1;
    wait_cyc(e0 + 3); start = 1'b0;
    wait_cyc(e0 + 12); pat = p1;
    wait_cyc(e0 + 13); mode = 1'b0;
    wait_cyc(e0 + 21);

    // stop sampled at E0+5 with D=2
    p0 = 4'($urandom);
    @(negedge clk);
    sv = snap_m;
    dwell = 4'd2; mode = 1'b0; pat = p0; start = 1'b1;
    e0 = cyc + 1;
    push_frame(e0, 2, p0, 1'b0, 1'b1);
    wait_cyc(e0); start = 1'b0;
    wait_cyc(e0 + 4); stop = 1'b1;
    trim(e0 + 5);
    snap_m = sv;
    push(e0 + 5, 2'd0, 1'b0, 1'b0, sv);
    push(e0 + 6, 2'd0, 1'b0, 1'b0, sv);
    wait_cyc(e0 + 5); stop = 1'b0;
    wait_cyc(e0 + 9);

    // stop with start in IDLE
    @(negedge clk);
    c = cyc;
    start = 1'b1; stop = 1'b1;
    push(c + 1, 2'd0, 1'b0, 1'b0, snap_m);
    push(c + 2, 2'd0, 1'b0, 1'b0, snap_m);
    wait_cyc(c + 1); start = 1'b0; stop = 1'b0;
    wait_cyc(c + 3);

    // asynchronous reset mid-frame
    p0 = 4'($urandom);
    @(negedge clk);
    dwell = 4'd3; mode = 1'b0; pat = p0; start = 1'b1;
    e0 = cyc + 1;
    push_frame(e0, 3, p0, 1'b0, 1'b1);
    wait_cyc(e0); start = 1'b0;
    wait_cyc(e0 + 5);
    #2 rst_n = 1'b0;
    trim(e0 + 6);
    snap_m = 4'd0;
    #1;
    chk("arst_sel", {s1, s0}, 2'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_snap", snap, 4'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    single(1, 4'($urandom));

    for (int i = 0; i < 8; i++) single(int'($urandom_range(0, 5)), 4'($urandom));

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
